// File: rtl/dma_arb_pkg.sv
// Shared types and default parameters for the MARIA/CPU DMA bus arbiter.
package dma_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SETTLE,
    ST_GRANT,
    ST_RELEASE,
    ST_COOLDOWN
  } arb_state_e;

  typedef struct packed {
    logic halt_b;
    logic dma_grant;
    logic memclk_fast;
    logic starve;
  } arb_out_t;

  localparam arb_out_t ARB_OUT_RST = '{halt_b: 1'b1, dma_grant: 1'b0, memclk_fast: 1'b0, starve: 1'b0};

  localparam int SETTLE_CYCLES_DEF  = 2;
  localparam int MAX_BURST_DEF      = 456;
  localparam int CPU_MIN_CYCLES_DEF = 1;
  localparam int WDOG_LIMIT_DEF     = 1024;

  // Width able to hold 0..n; never zero so tiny parameters still elaborate.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dma_arb_wdog.sv
// Watchdog for dma_arbiter: counts sysclk cycles spent outside IDLE and
// raises a sticky error when the limit is hit. Built only with DMA_ARB_WATCHDOG_EN.
module dma_arb_wdog
  import dma_arb_pkg::*;
#(
  parameter int LIMIT = WDOG_LIMIT_DEF
) (
  input  logic sysclk,
  input  logic RES_n,
  input  logic active,
  output logic fire,
  output logic err
);

  localparam int W = cnt_w(LIMIT);

  logic [W-1:0] cnt_q;

  // Fires on the edge where the count would reach LIMIT.
  assign fire = active && (cnt_q >= W'(LIMIT - 1));

  always_ff @(posedge sysclk or negedge RES_n) begin
    if (!RES_n) begin
      cnt_q <= '0;
      err   <= 1'b0;
    end else begin
      if (!active || fire)       cnt_q <= '0;
      else if (cnt_q < W'(LIMIT)) cnt_q <= cnt_q + W'(1);
      if (fire) err <= 1'b1;
    end
  end

endmodule

// File: rtl/dma_arbiter.sv
// MARIA/6502 bus arbiter: halts the CPU on a cycle boundary, grants the bus
// after a settle delay, bounds burst length. Optional watchdog: DMA_ARB_WATCHDOG_EN.
module dma_arbiter
  import dma_arb_pkg::*;
#(
  parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int MAX_BURST      = MAX_BURST_DEF,
  parameter int CPU_MIN_CYCLES = CPU_MIN_CYCLES_DEF,
  parameter int WDOG_LIMIT     = WDOG_LIMIT_DEF
) (
  input  logic sysclk,
  input  logic RES_n,
  input  logic cpu_ce,
  input  logic dma_req,
  input  logic dma_done,
  output logic halt_b,
  output logic dma_grant,
  output logic memclk_fast,
  output logic starve,
  output logic arb_err
);

  localparam int SW = cnt_w(SETTLE_CYCLES);
  localparam int BW = cnt_w(MAX_BURST);
  localparam int CW = cnt_w(CPU_MIN_CYCLES);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [CW-1:0] cool_q, cool_d;
  logic          trunc_q, trunc_d;
  arb_out_t      out_q, out_d;
  logic          wdog_fire;

  always_ff @(posedge sysclk or negedge RES_n) begin
    if (!RES_n) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      burst_q  <= '0;
      cool_q   <= '0;
      trunc_q  <= 1'b0;
      out_q    <= ARB_OUT_RST;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      burst_q  <= burst_d;
      cool_q   <= cool_d;
      trunc_q  <= trunc_d;
      out_q    <= out_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    burst_d  = burst_q;
    cool_d   = cool_q;
    trunc_d  = trunc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dma_req) begin
          if (cpu_ce) begin
            state_d  = ST_SETTLE;
            settle_d = SW'(SETTLE_CYCLES);
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      // A request withdrawn on the boundary cycle wins: no pointless halt.
      ST_REQ: begin
        if (!dma_req) begin
          state_d = ST_IDLE;
        end else if (cpu_ce) begin
          state_d  = ST_SETTLE;
          settle_d = SW'(SETTLE_CYCLES);
        end
      end
      ST_SETTLE: begin
        if (!dma_req) begin
          state_d = ST_RELEASE;
          trunc_d = 1'b0;
        end else if (settle_q <= SW'(1)) begin
          state_d  = ST_GRANT;
          settle_d = '0;
          burst_d  = BW'(1);
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      ST_GRANT: begin
        if (dma_done || !dma_req) begin
          state_d = ST_RELEASE;
          trunc_d = 1'b0;
        end else if (burst_q >= BW'(MAX_BURST)) begin
          state_d = ST_RELEASE;
          trunc_d = 1'b1;
        end else begin
          burst_d = burst_q + BW'(1);
        end
      end
      ST_RELEASE: begin
        if (cpu_ce) begin
          if (trunc_q && (CPU_MIN_CYCLES > 0)) begin
            state_d = ST_COOLDOWN;
            cool_d  = CW'(CPU_MIN_CYCLES);
          end else begin
            state_d = ST_IDLE;
          end
          trunc_d = 1'b0;
        end
      end
      ST_COOLDOWN: begin
        if (cpu_ce) begin
          if (cool_q <= CW'(1)) begin
            state_d = ST_IDLE;
            cool_d  = '0;
          end else begin
            cool_d = cool_q - CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (wdog_fire) begin
      state_d  = ST_IDLE;
      settle_d = '0;
      burst_d  = '0;
      cool_d   = '0;
      trunc_d  = 1'b0;
    end
  end

  // Outputs decode the next state so they change on the transition edge itself.
  always_comb begin
    out_d = ARB_OUT_RST;
    unique case (state_d)
      ST_SETTLE, ST_RELEASE: out_d.halt_b = 1'b0;
      ST_GRANT: begin
        out_d.halt_b      = 1'b0;
        out_d.dma_grant   = 1'b1;
        out_d.memclk_fast = 1'b1;
      end
      ST_COOLDOWN: out_d.starve = 1'b1;
      default: ;
    endcase
  end

  assign halt_b      = out_q.halt_b;
  assign dma_grant   = out_q.dma_grant;
  assign memclk_fast = out_q.memclk_fast;
  assign starve      = out_q.starve;

`ifdef DMA_ARB_WATCHDOG_EN
  logic wdog_active;
  assign wdog_active = (state_q != ST_IDLE);

  dma_arb_wdog #(.LIMIT(WDOG_LIMIT)) u_wdog (
    .sysclk (sysclk),
    .RES_n  (RES_n),
    .active (wdog_active),
    .fire   (wdog_fire),
    .err    (arb_err)
  );
`else
  assign wdog_fire = 1'b0;
  assign arb_err   = 1'b0;
`endif

endmodule
